spi_slave_responder: RTL and testbench

Mode-0 SPI responder: the target-side counterpart to the SoC's `spi_master`. Used for board-to-board links and for loopback bring-up of the master. It oversamples the external SCK, CS_N and MOSI pins in the system clock domain, shifts in received bytes and shifts out transmit bytes. Both byte streams are exchanged with the fabric over valid/ready handshakes. It sits beside the MMIO peripherals; a thin register wrapper, specified elsewhere, exposes its streams to the CPU.

---
 rtl/spi_slave_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - Mode-0 SPI target with oversampled pins and TX/RX byte handshakes
// Optional RX FIFO storage is enabled by defining SPI_SLAVE_RX_FIFO_EN; otherwise a single RX holding register is used.
module spi_slave_responder #(
  parameter int         RX_FIFO_AW = 4,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       selected,
  output logic       tx_underrun,
  output logic       rx_overrun,
  input  logic       err_clear
);

  typedef enum logic [1:0] {
    S_WAIT_DESELECT = 2'd0,
    S_IDLE          = 2'd1,
    S_ACTIVE        = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sck_s1, r_sck_s2, r_sck_s3;
  logic        r_cs_s1, r_cs_s2, r_cs_s3;
  logic        r_mosi_s1, r_mosi_s2;

  logic [2:0]  r_bit_cnt;
  logic        r_byte_done;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [7:0]  r_tx_hold;
  logic        r_tx_full;
  logic        r_tx_underrun;
  logic        r_rx_overrun;

  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic        w_load, w_shift_in, w_shift_out, w_abort, w_selected;
  logic        w_tx_accept;
  logic        w_rx_wr, w_rx_pop, w_rx_drop;
  logic [7:0]  w_rx_byte;

  assign w_sck_rise  =  r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall  = ~r_sck_s2 &  r_sck_s3;
  assign w_cs_fall   = ~r_cs_s2  &  r_cs_s3;
  assign w_cs_rise   =  r_cs_s2  & ~r_cs_s3;

  // Pin synchronizers; CS flops reset low so a CS held low through reset never looks like a deselect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_s3  <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_cs_s3   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT_DESELECT;
    else       r_state <= w_next_state;
  end

  // FSM next state plus per-cycle shift/load strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift_in   = 1'b0;
    w_shift_out  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_WAIT_DESELECT: begin
        if (r_cs_s2) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        if (w_cs_fall) begin
          w_next_state = S_ACTIVE;
          w_load       = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_next_state = S_IDLE;
          w_abort      = 1'b1;
        end else begin
          w_shift_in = w_sck_rise;
          if (w_sck_fall) begin
            if (r_byte_done) w_load      = 1'b1;
            else             w_shift_out = 1'b1;
          end
        end
      end
      default: w_next_state = S_WAIT_DESELECT;
    endcase
  end

  assign w_selected  = (r_state == S_ACTIVE) && !r_cs_s2;
  assign selected    = w_selected;
  assign spi_miso_oe = w_selected;
  assign spi_miso    = w_selected & r_tx_shift[7];

  assign w_rx_byte   = {r_rx_shift[6:0], r_mosi_s2};
  assign w_rx_wr     = w_shift_in && (r_bit_cnt == 3'd7);

  // Bit counter and shift registers; a new byte is loaded on CS fall and on the fall after every 8th rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 8'h00;
    end else begin
      if (w_abort || (w_load && r_state == S_IDLE)) begin
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
      end
      if (w_shift_in) begin
        r_rx_shift <= w_rx_byte;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
      end
      if (w_shift_out) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      if (w_load) begin
        r_tx_shift  <= r_tx_full ? r_tx_hold : IDLE_BYTE;
        r_byte_done <= 1'b0;
      end
    end
  end

  assign tx_ready    = ~r_tx_full;
  assign w_tx_accept = tx_valid && ~r_tx_full;

  // TX holding register; an accept in the same cycle as a load refills it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_full <= 1'b0;
      r_tx_hold <= 8'h00;
    end else begin
      if (w_load) r_tx_full <= 1'b0;
      if (w_tx_accept) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int RX_DEPTH = 1 << RX_FIFO_AW;

  logic [7:0]            r_mem [RX_DEPTH];
  logic [RX_FIFO_AW-1:0] r_wptr, r_rptr;
  logic [RX_FIFO_AW:0]   r_count;
  logic                  w_fifo_full, w_push;

  assign w_fifo_full = (r_count == RX_DEPTH[RX_FIFO_AW:0]);
  assign rx_valid    = (r_count != '0);
  assign rx_data     = r_mem[r_rptr];
  assign w_rx_pop    = rx_valid && rx_ready;
  assign w_rx_drop   = w_rx_wr && w_fifo_full && !w_rx_pop;
  assign w_push      = w_rx_wr && !w_rx_drop;

  // RX FIFO; a pop in the same cycle frees the slot the incoming byte needs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_rx_byte;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rx_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_rx_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign w_rx_pop  = r_rx_valid && rx_ready;
  assign w_rx_drop = w_rx_wr && r_rx_valid && !rx_ready;

  // Single RX holding register; held until popped, a second byte meanwhile is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else begin
      if (w_rx_pop) r_rx_valid <= 1'b0;
      if (w_rx_wr && !w_rx_drop) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end
    end
  end
`endif

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      if (w_load && !r_tx_full) r_tx_underrun <= 1'b1;
      else if (err_clear)       r_tx_underrun <= 1'b0;
      if (w_rx_drop)            r_rx_overrun  <= 1'b1;
      else if (err_clear)       r_rx_overrun  <= 1'b0;
    end
  end

  assign tx_underrun = r_tx_underrun;
  assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - self-checking bench for spi_slave_responder against a byte-level model
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       selected, tx_underrun, rx_overrun, err_clear;

  spi_slave_responder dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .selected(selected), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int CAP = 16;
`else
  localparam int CAP = 1;
`endif

  int         n_vec = 0;
  int         n_err = 0;

  bit         m_hold_full;
  logic [7:0] m_hold;
  bit         m_underrun, m_overrun;
  logic [7:0] m_rxq[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_start();
    logic [7:0] b;
    if (m_hold_full) begin
      b = m_hold;
      m_hold_full = 1'b0;
    end else begin
      b = 8'hFF;
      m_underrun = 1'b1;
    end
    return b;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input bit pop_same);
    if (pop_same && m_rxq.size() > 0) void'(m_rxq.pop_front());
    if (m_rxq.size() < CAP) m_rxq.push_back(b);
    else m_overrun = 1'b1;
  endfunction

  task automatic push_tx(input logic [7:0] b);
    check("tx_ready_before_push", {31'd0, tx_ready}, {31'd0, !m_hold_full});
    if (!m_hold_full) begin
      m_hold = b;
      m_hold_full = 1'b1;
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit pop_at_end);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      miso_cap = {miso_cap[6:0], spi_miso};
      spi_sck = 1'b1;
      if (pop_at_end && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic burst(input bit pop_last);
    logic [7:0] exp_miso, b;
    int n;
    n = mosi_q.size();
    cs_low();
    exp_miso = model_start();
    for (int k = 0; k < n; k++) begin
      b = mosi_q.pop_front();
      spi_bits(b, 8, pop_last && (k == n - 1));
      check("miso_byte", {24'd0, miso_cap}, {24'd0, exp_miso});
      check("selected_in_burst", {30'd0, selected, spi_miso_oe}, 32'd3);
      model_rx(b, pop_last && (k == n - 1));
      exp_miso = model_start();
    end
    cs_high();
  endtask

  task automatic check_flags();
    check("tx_underrun", {31'd0, tx_underrun}, {31'd0, m_underrun});
    check("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_overrun});
    check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_hold_full});
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    m_underrun = 1'b0;
    m_overrun = 1'b0;
    check("flags_after_clear", {30'd0, tx_underrun, rx_overrun}, 32'd0);
  endtask

  task automatic drain();
    logic [7:0] e;
    while (m_rxq.size() > 0) begin
      e = m_rxq.pop_front();
      check("rx_valid_drain", {31'd0, rx_valid}, 32'd1);
      check("rx_data", {24'd0, rx_data}, {24'd0, e});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
    end
    check("rx_valid_empty", {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clear = 1'b0;
    m_hold_full = 1'b0; m_hold = 8'h00; m_underrun = 1'b0; m_overrun = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_miso_oe_sel", {29'd0, spi_miso, spi_miso_oe, selected}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx", {23'd0, rx_valid, rx_data}, 32'd0);
    check("reset_flags", {30'd0, tx_underrun, rx_overrun}, 32'd0);
    repeat (4) @(negedge clk);

    // basic full-duplex byte
    push_tx(8'hA5);
    check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    mosi_q.push_back(8'h3C);
    burst(1'b0);
    check_flags();
    drain();
    clear_errors();

    // underrun then clear
    push_tx(8'h11);
    mosi_q.push_back(8'h01); mosi_q.push_back(8'h02); mosi_q.push_back(8'h03);
    burst(1'b0);
    check_flags();
    drain();
    clear_errors();

    // overrun with bytes 0..17 and consumer stalled
    for (int i = 0; i < 18; i++) mosi_q.push_back(i[7:0]);
    burst(1'b0);
    check_flags();
    drain();
    clear_errors();

    // pop coincides with the write that would otherwise overflow
    for (int i = 0; i <= CAP; i++) mosi_q.push_back(8'($urandom));
    burst(1'b1);
    check_flags();
    drain();
    clear_errors();

    // deselect mid-byte, then a clean 8'h77
    cs_low();
    void'(model_start());
    spi_bits(8'($urandom), 5, 1'b0);
    cs_high();
    check("no_rx_after_partial", {31'd0, rx_valid}, 32'd0);
    mosi_q.push_back(8'h77);
    burst(1'b0);
    drain();
    clear_errors();

    // reset during a transfer with CS held low
    cs_low();
    void'(model_start());
    spi_bits(8'($urandom), 3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hold_full = 1'b0; m_underrun = 1'b0; m_overrun = 1'b0;
    m_rxq.delete();
    spi_bits(8'($urandom), 8, 1'b0);
    spi_bits(8'($urandom), 8, 1'b0);
    check("sel_after_reset", {30'd0, selected, spi_miso_oe}, 32'd0);
    check("rx_after_reset", {31'd0, rx_valid}, 32'd0);
    check_flags();
    cs_high();
    mosi_q.push_back(8'h42);
    burst(1'b0);
    drain();
    clear_errors();

    // randomized bursts
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = 8'($urandom);
        push_tx(r);
      end
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) mosi_q.push_back(8'($urandom));
      burst(1'b0);
      check_flags();
      drain();
      if ($urandom_range(0, 1) == 1) clear_errors();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
